// File: rtl/mem_arbiter2_pkg.sv
// Shared widths, grant-state encodings and master selects
// for the two-master SRAM port arbiter.
package mem_arbiter2_pkg;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } grant_e;

  localparam logic MA = 1'b0;
  localparam logic MB = 1'b1;
endpackage

// File: rtl/mem_arbiter2_tagfifo.sv
// 1-bit master-identity FIFO that tracks outstanding reads
// so in-order responses return to the issuing master.
module mem_arbiter2_tagfifo
  import mem_arbiter2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter sharing one sram16_ctrl port between two
// masters; read beats are routed back via a tag FIFO.
module mem_arbiter2
  import mem_arbiter2_pkg::*;
#(
  parameter int TAG_DEPTH  = 4,
  parameter int READ_BEATS = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              a_mem_read,
  input  logic              a_mem_write,
  input  logic [ID_W-1:0]   a_mem_id,
  input  logic [ADDR_W-1:0] a_mem_address,
  input  logic [DATA_W-1:0] a_mem_writedata,
  input  logic [MASK_W-1:0] a_mem_writedatamask,
  output logic              a_mem_waitrequest,
  output logic [DATA_W-1:0] a_mem_readdata,
  output logic [ID_W-1:0]   a_mem_readdataid,
  input  logic              b_mem_read,
  input  logic              b_mem_write,
  input  logic [ID_W-1:0]   b_mem_id,
  input  logic [ADDR_W-1:0] b_mem_address,
  input  logic [DATA_W-1:0] b_mem_writedata,
  input  logic [MASK_W-1:0] b_mem_writedatamask,
  output logic              b_mem_waitrequest,
  output logic [DATA_W-1:0] b_mem_readdata,
  output logic [ID_W-1:0]   b_mem_readdataid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ID_W-1:0]   mem_id,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [MASK_W-1:0] mem_writedatamask,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic [ID_W-1:0]   mem_readdataid,
  output logic              protocol_error
);
  localparam int BW = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(READ_BEATS - 1);

  grant_e        r_state;
  grant_e        w_next;
  logic          r_last;
  logic [BW-1:0] r_beat;
  logic          r_perr;

  logic w_req_a, w_req_b;
  logic w_rd_a, w_rd_b;
  logic w_acc, w_push, w_pop, w_gnt;
  logic w_full, w_empty, w_head;
  logic w_beat, w_route;

  // A simultaneous write wins, so a read is only honoured alone
  assign w_req_a = a_mem_read | a_mem_write;
  assign w_req_b = b_mem_read | b_mem_write;
  assign w_rd_a  = a_mem_read & ~a_mem_write;
  assign w_rd_b  = b_mem_read & ~b_mem_write;
  assign w_gnt   = (r_state == GRANT_B) ? MB : MA;
  assign w_push  = w_acc & mem_read;

  always_comb begin
    w_next            = r_state;
    w_acc             = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_id            = '0;
    mem_address       = '0;
    mem_writedata     = '0;
    mem_writedatamask = '0;
    a_mem_waitrequest = 1'b1;
    b_mem_waitrequest = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_req_a && w_req_b)
          w_next = (r_last == MA) ? GRANT_B : GRANT_A;
        else if (w_req_a)
          w_next = GRANT_A;
        else if (w_req_b)
          w_next = GRANT_B;
      end
      GRANT_A: begin
        mem_write         = a_mem_write;
        mem_read          = w_rd_a & ~w_full;
        mem_id            = a_mem_id;
        mem_address       = a_mem_address;
        mem_writedata     = a_mem_writedata;
        mem_writedatamask = a_mem_writedatamask;
        a_mem_waitrequest = mem_waitrequest
                          | (w_rd_a & w_full);
        w_acc  = (mem_read | mem_write) & ~mem_waitrequest;
        if (w_acc || !w_req_a)
          w_next = IDLE;
      end
      GRANT_B: begin
        mem_write         = b_mem_write;
        mem_read          = w_rd_b & ~w_full;
        mem_id            = b_mem_id;
        mem_address       = b_mem_address;
        mem_writedata     = b_mem_writedata;
        mem_writedatamask = b_mem_writedatamask;
        b_mem_waitrequest = mem_waitrequest
                          | (w_rd_b & w_full);
        w_acc  = (mem_read | mem_write) & ~mem_waitrequest;
        if (w_acc || !w_req_b)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= MB;
    end else begin
      r_state <= w_next;
      if (w_acc)
        r_last <= w_gnt;
    end
  end

  mem_arbiter2_tagfifo #(
    .DEPTH (TAG_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_gnt),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Beats with no outstanding tag are dropped and flagged
  assign w_beat  = (mem_readdataid != '0);
  assign w_route = w_beat & ~w_empty;
  assign w_pop   = w_route & (r_beat == LAST_BEAT);

  assign a_mem_readdata   = mem_readdata;
  assign b_mem_readdata   = mem_readdata;
  assign a_mem_readdataid = (w_route && w_head == MA)
                          ? mem_readdataid : '0;
  assign b_mem_readdataid = (w_route && w_head == MB)
                          ? mem_readdataid : '0;
  assign protocol_error   = r_perr;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_perr <= 1'b0;
    end else begin
      if (w_route)
        r_beat <= w_pop ? '0 : r_beat + BW'(1);
      if (w_beat && w_empty)
        r_perr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter2.sv
// Scoreboard bench for mem_arbiter2: single-beat and 4-beat
// instances share master stimulus, each has its own SRAM side.
module tb_mem_arbiter2;
  import mem_arbiter2_pkg::*;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  id;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  typedef struct packed {
    logic        dst;
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic rst_n;

  logic        a_rd, a_wr, b_rd, b_wr;
  logic [1:0]  a_id, b_id;
  logic [29:0] a_addr, b_addr;
  logic [31:0] a_wd, b_wd;
  logic [3:0]  a_mask, b_mask;

  logic        a_wait1, b_wait1, m_rd1, m_wr1, perr1;
  logic [31:0] a_rdata1, b_rdata1, m_wd1;
  logic [1:0]  a_rid1, b_rid1, m_id1;
  logic [29:0] m_addr1;
  logic [3:0]  m_mask1;
  logic        mwait1;
  logic [31:0] mrdata1;
  logic [1:0]  mrid1;

  logic        a_wait4, b_wait4, m_rd4, m_wr4, perr4;
  logic [31:0] a_rdata4, b_rdata4, m_wd4;
  logic [1:0]  a_rid4, b_rid4, m_id4;
  logic [29:0] m_addr4;
  logic [3:0]  m_mask4;
  logic        mwait4;
  logic [31:0] man_data4;
  logic [1:0]  man_id4;

  logic        rsp_auto;
  logic [1:0]  man_id1;
  logic [31:0] man_data1;
  logic        p0v, p1v, cv;
  logic [1:0]  p0id, p1id, cid;
  logic [29:0] p0a, p1a, ca;

  int   checks = 0;
  int   failures = 0;
  int   n_acc1 = 0;
  int   n_acc4 = 0;
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  rsp_t exp_rsp4[$];
  req_t mr;
  rsp_t ms;

  always #5 clock = ~clock;

  assign mrid1   = rsp_auto ? (p1v ? p1id : 2'b00) : man_id1;
  assign mrdata1 = rsp_auto ? {p1id, p1a} : man_data1;

  mem_arbiter2 #(.TAG_DEPTH(4), .READ_BEATS(1)) u_dut (
    .clock(clock), .rst_n(rst_n),
    .a_mem_read(a_rd), .a_mem_write(a_wr), .a_mem_id(a_id),
    .a_mem_address(a_addr), .a_mem_writedata(a_wd),
    .a_mem_writedatamask(a_mask), .a_mem_waitrequest(a_wait1),
    .a_mem_readdata(a_rdata1), .a_mem_readdataid(a_rid1),
    .b_mem_read(b_rd), .b_mem_write(b_wr), .b_mem_id(b_id),
    .b_mem_address(b_addr), .b_mem_writedata(b_wd),
    .b_mem_writedatamask(b_mask), .b_mem_waitrequest(b_wait1),
    .b_mem_readdata(b_rdata1), .b_mem_readdataid(b_rid1),
    .mem_read(m_rd1), .mem_write(m_wr1), .mem_id(m_id1),
    .mem_address(m_addr1), .mem_writedata(m_wd1),
    .mem_writedatamask(m_mask1), .mem_waitrequest(mwait1),
    .mem_readdata(mrdata1), .mem_readdataid(mrid1),
    .protocol_error(perr1)
  );

  mem_arbiter2 #(.TAG_DEPTH(4), .READ_BEATS(4)) u_dut4 (
    .clock(clock), .rst_n(rst_n),
    .a_mem_read(a_rd), .a_mem_write(a_wr), .a_mem_id(a_id),
    .a_mem_address(a_addr), .a_mem_writedata(a_wd),
    .a_mem_writedatamask(a_mask), .a_mem_waitrequest(a_wait4),
    .a_mem_readdata(a_rdata4), .a_mem_readdataid(a_rid4),
    .b_mem_read(b_rd), .b_mem_write(b_wr), .b_mem_id(b_id),
    .b_mem_address(b_addr), .b_mem_writedata(b_wd),
    .b_mem_writedatamask(b_mask), .b_mem_waitrequest(b_wait4),
    .b_mem_readdata(b_rdata4), .b_mem_readdataid(b_rid4),
    .mem_read(m_rd4), .mem_write(m_wr4), .mem_id(m_id4),
    .mem_address(m_addr4), .mem_writedata(m_wd4),
    .mem_writedatamask(m_mask4), .mem_waitrequest(mwait4),
    .mem_readdata(man_data4), .mem_readdataid(man_id4),
    .protocol_error(perr4)
  );

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_req(input logic wr, input logic rd,
                          input logic [1:0] id,
                          input logic [29:0] addr,
                          input logic [31:0] data,
                          input logic [3:0] mask);
    req_t r;
    r = {wr, rd, id, addr, data, mask};
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input bit four, input logic dst,
                          input logic [1:0] id,
                          input logic [31:0] data);
    rsp_t s;
    s = {dst, id, data};
    if (four) exp_rsp4.push_back(s);
    else exp_rsp.push_back(s);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_acc(input int tgt, input bit four,
                          input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if ((four ? n_acc4 : n_acc1) >= tgt) done = 1'b1;
    end
    if (!done) fail({nm, " accept timeout"});
  endtask

  // Scoreboard monitor: accepts and response beats, both DUTs
  always @(negedge clock) begin
    if (rst_n) begin
      if ((m_rd1 || m_wr1) && !mwait1) begin
        n_acc1++;
        if (exp_req.size() == 0) fail("req_unexpected");
        else begin
          mr = exp_req.pop_front();
          chk("req_ctl", {m_wr1, m_rd1, m_id1},
              {mr.wr, mr.rd, mr.id});
          chk("req_addr", m_addr1, mr.addr);
          chk("req_data", {m_wd1, m_mask1}, {mr.data, mr.mask});
        end
      end
      if (a_rid1 != 0 || b_rid1 != 0) begin
        if (exp_rsp.size() == 0) fail("rsp_unexpected");
        else begin
          ms = exp_rsp.pop_front();
          chk("rsp_route", {a_rid1, b_rid1},
              ms.dst ? {2'b00, ms.id} : {ms.id, 2'b00});
          chk("rsp_data", {a_rdata1, b_rdata1}, {ms.data, ms.data});
        end
      end
      if ((m_rd4 || m_wr4) && !mwait4) n_acc4++;
      if (a_rid4 != 0 || b_rid4 != 0) begin
        if (exp_rsp4.size() == 0) fail("rsp4_unexpected");
        else begin
          ms = exp_rsp4.pop_front();
          chk("rsp4_route", {a_rid4, b_rid4},
              ms.dst ? {2'b00, ms.id} : {ms.id, 2'b00});
          chk("rsp4_data", a_rdata4, ms.data);
        end
      end
    end
  end

  // SRAM model for dut1: one beat two cycles after a read accept
  initial begin
    p0v = 1'b0; p1v = 1'b0;
    p0id = '0; p1id = '0; p0a = '0; p1a = '0;
    forever begin
      @(negedge clock);
      cv  = m_rd1 && !mwait1 && rst_n;
      cid = m_id1;
      ca  = m_addr1;
      @(posedge clock);
      #1;
      p1v = p0v; p1id = p0id; p1a = p0a;
      p0v = cv && rsp_auto; p0id = cid; p0a = ca;
    end
  end

  initial begin
    #100000;
    fail("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst_n = 1'b1;
    {a_rd, a_wr, b_rd, b_wr} = '0;
    a_id = '0; b_id = '0; a_addr = '0; b_addr = '0;
    a_wd = '0; b_wd = '0; a_mask = '0; b_mask = '0;
    mwait1 = 1'b1; mwait4 = 1'b1; rsp_auto = 1'b0;
    man_id1 = '0; man_data1 = '0;
    man_id4 = '0; man_data4 = '0;
    #1 rst_n = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_wait", {a_wait1, b_wait1, a_wait4, b_wait4}, 4'hF);
    chk("rst_strobe", {m_rd1, m_wr1, m_rd4, m_wr4}, 4'h0);
    chk("rst_rid", {a_rid1, b_rid1}, 4'h0);
    chk("rst_perr", perr1, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // A write held off by waitrequest for 3 cycles
    a_wr = 1'b1; a_addr = 30'h0000100;
    a_wd = 32'hDEADBEEF; a_mask = 4'hF;
    push_req(1, 0, 2'd0, 30'h100, 32'hDEADBEEF, 4'hF);
    @(negedge clock);
    chk("w_idle", {a_wait1, m_wr1}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("w_fwd_ctl", {m_wr1, m_rd1, a_wait1, b_wait1}, 4'b1011);
      chk("w_fwd_addr", m_addr1, 30'h100);
      chk("w_fwd_data", {m_wd1, m_mask1}, {32'hDEADBEEF, 4'hF});
    end
    cyc();
    mwait1 = 1'b0;
    @(negedge clock);
    chk("w_acc_wait", {a_wait1, b_wait1}, 2'b01);
    cyc();
    a_wr = 1'b0; a_wd = '0; a_mask = '0; mwait1 = 1'b1;
    @(negedge clock);
    chk("w_fifo_cnt", u_dut.u_fifo.r_count, 0);

    // B write, leaves last_grant = B
    b_wr = 1'b1; b_addr = 30'h2A;
    b_wd = 32'h12345678; b_mask = 4'h3;
    push_req(1, 0, 2'd0, 30'h2A, 32'h12345678, 4'h3);
    mwait1 = 1'b0;
    t = n_acc1 + 1;
    wait_acc(t, 0, "b_write");
    b_wr = 1'b0; b_wd = '0; b_mask = '0;

    // contention: both read continuously
    rsp_auto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1, 2'd1, 30'h10, 32'h0, 4'h0);
      push_req(0, 1, 2'd2, 30'h20, 32'h0, 4'h0);
      push_rsp(0, 1'b0, 2'd1, {2'd1, 30'h10});
      push_rsp(0, 1'b1, 2'd2, {2'd2, 30'h20});
    end
    a_rd = 1'b1; a_id = 2'd1; a_addr = 30'h10;
    b_rd = 1'b1; b_id = 2'd2; b_addr = 30'h20;
    t = n_acc1 + 8;
    wait_acc(t, 0, "contention");
    a_rd = 1'b0; b_rd = 1'b0;
    repeat (5) cyc();
    rsp_auto = 1'b0;
    @(negedge clock);
    chk("cont_fifo_cnt", u_dut.u_fifo.r_count, 0);
    chk("cont_rsp_left", exp_rsp.size(), 0);

    // fill the tag FIFO from B
    for (int i = 0; i < 4; i++)
      push_req(0, 1, 2'd2, 30'h30, 32'h0, 4'h0);
    b_rd = 1'b1; b_id = 2'd2; b_addr = 30'h30;
    t = n_acc1 + 4;
    wait_acc(t, 0, "fill");
    b_rd = 1'b0;
    @(negedge clock);
    chk("full_cnt", u_dut.u_fifo.r_count, 4);
    cyc();
    a_rd = 1'b1; a_id = 2'd1; a_addr = 30'h44;
    push_req(0, 1, 2'd1, 30'h44, 32'h0, 4'h0);
    push_rsp(0, 1'b1, 2'd2, 32'hC0DE0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("full_block", {m_rd1, a_wait1, b_wait1}, 3'b011);
    end
    cyc();
    man_id1 = 2'd2; man_data1 = 32'hC0DE0001;
    @(negedge clock);
    chk("full_pop_cycle", {m_rd1, a_wait1}, 2'b01);
    cyc();
    man_id1 = '0;
    @(negedge clock);
    chk("full_release", {m_rd1, a_wait1}, 2'b10);
    cyc();
    a_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_rsp(0, i < 3 ? 1'b1 : 1'b0, i < 3 ? 2'd2 : 2'd1,
               32'hC0DE0002 + 32'(i));
      man_id1 = i < 3 ? 2'd2 : 2'd1;
      man_data1 = 32'hC0DE0002 + 32'(i);
      cyc();
    end
    man_id1 = '0;
    @(negedge clock);
    chk("drain_cnt", u_dut.u_fifo.r_count, 0);

    // multi-beat on the READ_BEATS=4 instance
    mwait1 = 1'b1; mwait4 = 1'b0;
    a_rd = 1'b1; a_id = 2'd3; a_addr = 30'h50;
    t = n_acc4 + 1;
    wait_acc(t, 1, "mb_a");
    a_rd = 1'b0;
    b_rd = 1'b1; b_id = 2'd1; b_addr = 30'h60;
    t = n_acc4 + 1;
    wait_acc(t, 1, "mb_b");
    b_rd = 1'b0; mwait4 = 1'b1;
    @(negedge clock);
    chk("mb_cnt", u_dut4.u_fifo.r_count, 2);
    for (int i = 0; i < 8; i++) begin
      cyc();
      push_rsp(1, i < 4 ? 1'b0 : 1'b1, i < 4 ? 2'd3 : 2'd1,
               32'hA0000000 + 32'(i));
      man_id4 = i < 4 ? 2'd3 : 2'd1;
      man_data4 = 32'hA0000000 + 32'(i);
    end
    cyc();
    man_id4 = '0;
    @(negedge clock);
    chk("mb_end_cnt", u_dut4.u_fifo.r_count, 0);
    chk("mb_end_beat", u_dut4.r_beat, 0);
    chk("mb_no_perr", perr4, 1'b0);

    // orphan beat, then reset mid-grant
    cyc();
    man_id1 = 2'd2; man_data1 = 32'h0BAD0BAD;
    @(negedge clock);
    chk("err_rid", {a_rid1, b_rid1}, 4'h0);
    chk("err_pre", perr1, 1'b0);
    cyc();
    man_id1 = '0;
    chk("err_set", perr1, 1'b1);
    cyc();
    chk("err_sticky", perr1, 1'b1);
    a_wr = 1'b1; a_addr = 30'h77; mwait1 = 1'b1;
    cyc();
    cyc();
    @(negedge clock);
    chk("rst_pre_grant", {m_wr1, a_wait1}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_perr", perr1, 1'b0);
    chk("rst_async_wait", {a_wait1, b_wait1}, 2'b11);
    chk("rst_async_wr", m_wr1, 1'b0);
    chk("rst_async_state", u_dut.r_state, IDLE);
    a_wr = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    chk("end_req_q", exp_req.size(), 0);
    chk("end_rsp_q", exp_rsp.size(), 0);
    chk("end_rsp4_q", exp_rsp4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-master arbiter that shares the single sram16_ctrl memory port.
- Master A is the yari CPU memory port; master B is a second bus master, such as a serial boot loader or DMA.
- Round-robin grant with a registered grant state machine.
- Routes in-order read responses back to the issuing master using a small tag FIFO of master identities.

Parameters:
- TAG_DEPTH, 4: max outstanding accepted reads; power of two, ≥2.
- READ_BEATS, 1: response beats returned by the downstream for each accepted read.

Ports:
- clock in 1: system clock.
- rst_n in 1: reset, asynchronous assert, active low.
- a_mem_read / a_mem_write in 1 each: master A request strobes.
- a_mem_id in 2: master A transaction id; nonzero for reads.
- a_mem_address in 30: word address.
- a_mem_writedata in 32; a_mem_writedatamask in 4.
- a_mem_waitrequest out 1: A request not accepted this cycle.
- a_mem_readdata out 32; a_mem_readdataid out 2: nonzero = valid beat for A.
- b_mem_* : same set as a_mem_*, for master B.
- mem_read / mem_write out 1: to sram16_ctrl.
- mem_id out 2; mem_address out 30; mem_writedata out 32; mem_writedatamask out 4.
- mem_waitrequest in 1; mem_readdata in 32; mem_readdataid in 2: from sram16_ctrl.
- protocol_error out 1: sticky; a response beat arrived with the tag FIFO empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; last_grant = B, so A wins the first tie.
  - Tag FIFO empty; beat counter 0; protocol_error 0.
  - a/b_mem_waitrequest = 1; mem_read = mem_write = 0.
  - a/b_mem_readdataid = 0.
  - Reset mid-transfer discards all state. sram16_ctrl shares the reset.
- Request definition: req_x = x_mem_read | x_mem_write. Read and write together is illegal; write takes priority.
- States:
  - IDLE:
    - Downstream strobes low; both waitrequests high.
    - Only A requests -> GRANT_A. Only B requests -> GRANT_B.
    - Both request -> grant the master that is not last_grant.
    - Arbitration costs 1 cycle.
  - GRANT_x:
    - mem_address, mem_id, mem_writedata, mem_writedatamask and mem_write are muxed combinationally from master x.
    - mem_read = x_mem_read & ~tag_full.
    - x_mem_waitrequest = mem_waitrequest | (x_mem_read & tag_full). The other master's waitrequest = 1.
    - Accept = forwarded strobe & ~mem_waitrequest.
    - On accept: last_grant <= x; next state IDLE.
    - If req_x drops without acceptance (master protocol violation): return to IDLE, no side effects.
- Throughput: at most 1 accepted transfer per 2 cycles. This is acceptable because the 16-bit SRAM needs at least 2 cycles per 32-bit word.
- Tag FIFO:
  - Push the granted master identity (1 bit) on read accept only. Writes carry no tag.
  - tag_full = (count == TAG_DEPTH). A pop in the same cycle does not relieve full.
  - Pointers wrap modulo TAG_DEPTH; count width is clog2(TAG_DEPTH)+1.
  - Simultaneous push and pop: count unchanged; both pointers advance.
- Response routing:
  - Valid beat = mem_readdataid != 0.
  - mem_readdata is broadcast to both a_mem_readdata and b_mem_readdata every cycle.
  - On a valid beat, the head-tag master's readdataid = mem_readdataid; the other master's = 0. Combinational, 0 cycles added latency.
  - The beat counter increments per valid beat. On beat READ_BEATS-1 the counter resets to 0 and the FIFO pops.
  - Valid beat with FIFO empty: both readdataid = 0, beat dropped, protocol_error <= 1 until reset.
- Masters must hold their request stable while waitrequest is high. The arbiter never switches grant while the granted request is held.

Decomposition:
- Shared package holds the bus widths (ADDR_W = 30, DATA_W = 32, MASK_W = 4, ID_W = 2), the grant-state encodings IDLE/GRANT_A/GRANT_B, and the master-select constants MA = 0, MB = 1.
- One sub-module: mem_arbiter2_tagfifo. It is a 1-bit wide, TAG_DEPTH deep synchronous FIFO with async active-low reset and push, pop, head, full and empty signals.
- The response beat counter and router stay in the top module.

Test Plan:
- A only:
  - Stimulus: A write to addr 0x0000100, data 0xDEADBEEF, mask 0xF; mem_waitrequest held high 3 cycles.
  - Response: mem_write high with A's fields throughout; a_mem_waitrequest low only in the accept cycle; b_mem_waitrequest stays 1; tag FIFO count stays 0.
- Contention:
  - Stimulus: A and B both read continuously, A id 1, B id 2, READ_BEATS = 1, sram returns one beat 2 cycles after each accept.
  - Response: grants alternate A, B, A, B; each a_mem_readdataid == 1 beat reaches A only; each id-2 beat reaches B only.
- Full FIFO:
  - Stimulus: TAG_DEPTH = 4; 4 reads accepted from B with no responses returned; A then issues a read.
  - Response: mem_read stays 0 and a_mem_waitrequest stays 1. After 1 response beat (popping the FIFO), A's read is forwarded on the next cycle.
- Multi-beat:
  - Stimulus: READ_BEATS = 4; A reads then B reads; downstream returns 8 beats with ids 3, 3, 3, 3, 1, 1, 1, 1.
  - Response: the first 4 beats go to A with a_mem_readdataid = 3; the next 4 go to B with b_mem_readdataid = 1; FIFO ends empty.
- Error and reset:
  - Stimulus: inject mem_readdataid = 2 with the FIFO empty; then pulse rst_n low mid-grant.
  - Response: protocol_error goes to 1 and both readdataid stay 0. The reset asynchronously clears protocol_error, returns state to IDLE, and drives both waitrequests to 1 before the next clock edge.
